booth_mcand_buf: RTL and testbench

Parametrised, double-buffered multiplicand register for the Booth multiplier datapath. The upstream side loads the next multiplicand into a shadow register through a valid/ready handshake while the current multiplication runs. The Booth controller promotes the shadow register into the active register with a take pulse. Each cycle, the block emits a registered, sign-extended partial product (0, ±M, ±2M) selected by the Booth code.

---
 rtl/booth_mcand_buf_if.sv | 21 ++
 rtl/booth_mcand_buf.sv | 114 +++++++++++
 tb/tb_booth_mcand_buf.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mcand_buf_if.sv
// Upstream load handshake for the Booth multiplicand buffer.
// The master offers in_data and the slave returns in_ready.
interface booth_mcand_buf_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/booth_mcand_buf.sv
// Double-buffered Booth multiplicand with registered partial product.
// The shadow register loads upstream data; take promotes it to active.
module booth_mcand_buf #(
  parameter int WIDTH  = 8,
  parameter int RADIX4 = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  booth_mcand_buf_if.slave   up,
  input  logic               take,
  input  logic               clear,
  input  logic               pp_en,
  input  logic [2:0]         sel,
  output logic               act_valid,
  output logic [WIDTH-1:0]   mcand_o,
  output logic [WIDTH+1:0]   pp_out
);

  localparam int PW = WIDTH + 2;
  localparam bit R4 = (RADIX4 != 0);

  logic [WIDTH-1:0] r_shd;
  logic             r_full;
  logic [WIDTH-1:0] r_act;
  logic             r_av;
  logic [PW-1:0]    r_pm;
  logic [PW-1:0]    r_nm;
  logic [PW-1:0]    r_p2;
  logic [PW-1:0]    r_n2;
  logic [PW-1:0]    r_pp;

  logic          w_take_fire;
  logic          w_in_ready;
  logic          w_load_fire;
  logic [PW-1:0] w_sext;
  logic [PW-1:0] w_neg;
  logic          w_pos;
  logic          w_negm;
  logic          w_pos2;
  logic          w_neg2;
  logic [PW-1:0] w_pp;

  assign w_take_fire = take & r_full;
  assign w_in_ready  = ~r_full | w_take_fire;
  assign w_load_fire = up.in_valid & w_in_ready;
  assign up.in_ready = w_in_ready;

  // Terms are widened first so -M and -2M of the most negative value stay exact
  assign w_sext = {{2{r_shd[WIDTH-1]}}, r_shd};
  assign w_neg  = ~w_sext + PW'(1);

  assign w_pos  = R4 ? (sel == 3'd1 || sel == 3'd2)
                     : (sel[1:0] == 2'd1);
  assign w_negm = R4 ? (sel == 3'd5 || sel == 3'd6)
                     : (sel[1:0] == 2'd2);
  assign w_pos2 = R4 && (sel == 3'd3);
  assign w_neg2 = R4 && (sel == 3'd4);

  always_comb begin
    w_pp = '0;
    unique case (1'b1)
      w_pos:   w_pp = r_pm;
      w_negm:  w_pp = r_nm;
      w_pos2:  w_pp = r_p2;
      w_neg2:  w_pp = r_n2;
      default: w_pp = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shd  <= '0;
      r_full <= 1'b0;
    end else if (w_load_fire) begin
      r_shd  <= up.in_data;
      r_full <= 1'b1;
    end else if (w_take_fire) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act <= '0;
      r_av  <= 1'b0;
      r_pm  <= '0;
      r_nm  <= '0;
      r_p2  <= '0;
      r_n2  <= '0;
    end else if (w_take_fire) begin
      r_act <= r_shd;
      r_av  <= 1'b1;
      r_pm  <= w_sext;
      r_nm  <= w_neg;
      r_p2  <= w_sext << 1;
      r_n2  <= w_neg << 1;
    end else if (clear) begin
      r_av  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pp <= '0;
    end else if (pp_en) begin
      r_pp <= r_av ? w_pp : '0;
    end
  end

  assign act_valid = r_av;
  assign mcand_o   = r_act;
  assign pp_out    = r_pp;

endmodule

// File: tb/tb_booth_mcand_buf.sv
// Bench for booth_mcand_buf: radix-4 and radix-2 instances share stimulus.
// A plain-arithmetic model predicts every output each cycle.
module tb_booth_mcand_buf;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       take;
  logic       clear;
  logic       pp_en;
  logic [2:0] sel;

  logic       av4, av2;
  logic [7:0] mc4, mc2;
  logic [9:0] pp4, pp2;

  int errs;
  int checks;

  booth_mcand_buf_if #(.WIDTH(8)) u_if4 ();
  booth_mcand_buf_if #(.WIDTH(8)) u_if2 ();

  assign u_if4.in_valid = in_valid;
  assign u_if4.in_data  = in_data;
  assign u_if2.in_valid = in_valid;
  assign u_if2.in_data  = in_data;

  booth_mcand_buf #(.WIDTH(8), .RADIX4(1)) u_r4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .up        (u_if4),
    .take      (take),
    .clear     (clear),
    .pp_en     (pp_en),
    .sel       (sel),
    .act_valid (av4),
    .mcand_o   (mc4),
    .pp_out    (pp4)
  );

  booth_mcand_buf #(.WIDTH(8), .RADIX4(0)) u_r2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .up        (u_if2),
    .take      (take),
    .clear     (clear),
    .pp_en     (pp_en),
    .sel       (sel),
    .act_valid (av2),
    .mcand_o   (mc2),
    .pp_out    (pp2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  bit         m_full;
  logic [7:0] m_shd;
  logic [7:0] m_act;
  bit         m_av;
  logic [9:0] m_pp4;
  logic [9:0] m_pp2;

  function automatic int dec(bit r4, logic [2:0] s);
    int d;
    d = 0;
    if (r4) begin
      case (s)
        3'd1, 3'd2: d = 1;
        3'd3:       d = 2;
        3'd4:       d = -2;
        3'd5, 3'd6: d = -1;
        default:    d = 0;
      endcase
    end else begin
      case (s[1:0])
        2'd1:    d = 1;
        2'd2:    d = -1;
        default: d = 0;
      endcase
    end
    return d;
  endfunction

  function automatic logic [9:0] ppv(bit r4, logic [2:0] s);
    int p;
    p = dec(r4, s) * int'($signed(m_act));
    return p[9:0];
  endfunction

  task automatic model_reset();
    m_full = 0;
    m_shd  = '0;
    m_act  = '0;
    m_av   = 0;
    m_pp4  = '0;
    m_pp2  = '0;
  endtask

  task automatic model_step();
    bit tf, rdy, lf;
    tf  = take && m_full;
    rdy = !m_full || tf;
    lf  = in_valid && rdy;
    if (pp_en) begin
      m_pp4 = m_av ? ppv(1'b1, sel) : 10'd0;
      m_pp2 = m_av ? ppv(1'b0, sel) : 10'd0;
    end
    if (tf) begin
      m_act = m_shd;
      m_av  = 1;
    end else if (clear) begin
      m_av  = 0;
    end
    if (lf) begin
      m_shd  = in_data;
      m_full = 1;
    end else if (tf) begin
      m_full = 0;
    end
  endtask

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic check_all();
    logic rdy;
    rdy = !m_full || (take && m_full);
    chk("rdy4", 32'(u_if4.in_ready), 32'(rdy));
    chk("rdy2", 32'(u_if2.in_ready), 32'(rdy));
    chk("av4", 32'(av4), 32'(m_av));
    chk("av2", 32'(av2), 32'(m_av));
    chk("mc4", 32'(mc4), 32'(m_act));
    chk("mc2", 32'(mc2), 32'(m_act));
    chk("pp4", 32'(pp4), 32'(m_pp4));
    chk("pp2", 32'(pp2), 32'(m_pp2));
  endtask

  task automatic setin(bit v, logic [7:0] d, bit t,
                       bit c, bit e, logic [2:0] s);
    in_valid = v;
    in_data  = d;
    take     = t;
    clear    = c;
    pp_en    = e;
    sel      = s;
  endtask

  // Called right after a falling edge with inputs already driven
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_take(logic [7:0] d);
    setin(1, d, 0, 0, 0, 3'd0);
    cycle();
    setin(0, 8'h00, 1, 0, 0, 3'd0);
    cycle();
  endtask

  task automatic pp_at(logic [2:0] s);
    setin(0, 8'h00, 0, 0, 1, s);
    cycle();
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst_n  = 1'b0;
    setin(0, 8'h00, 0, 0, 0, 3'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    setin(1, 8'h5A, 0, 0, 0, 3'd0);
    cycle();
    setin(0, 8'h00, 0, 0, 0, 3'd0);
    do_reset();
    chk("rst_av", 32'(av4), 32'd0);
    chk("rst_pp", 32'(pp4), 32'd0);
    chk("rst_rdy", 32'(u_if4.in_ready), 32'd1);
    setin(0, 8'h00, 1, 0, 0, 3'd0);
    cycle();
    chk("rst_empty", 32'(av4), 32'd0);

    load_take(8'h13);
    pp_at(3'd1); chk("r4_p1", 32'(pp4), 32'h013);
    pp_at(3'd3); chk("r4_p2", 32'(pp4), 32'h026);
    pp_at(3'd4); chk("r4_n2", 32'(pp4), 32'h3DA);
    pp_at(3'd5); chk("r4_n1", 32'(pp4), 32'h3ED);
    pp_at(3'd7); chk("r4_z", 32'(pp4), 32'h000);

    load_take(8'h80);
    pp_at(3'd6); chk("ext_n1", 32'(pp4), 32'h080);
    pp_at(3'd4); chk("ext_n2", 32'(pp4), 32'h100);
    pp_at(3'd3); chk("ext_p2", 32'(pp4), 32'h300);

    setin(1, 8'h11, 0, 0, 0, 3'd0);
    cycle();
    setin(1, 8'h22, 0, 0, 0, 3'd0);
    #1;
    chk("bp_rdy0", 32'(u_if4.in_ready), 32'd0);
    cycle();
    setin(1, 8'h22, 1, 0, 0, 3'd0);
    #1;
    chk("bp_rdy1", 32'(u_if4.in_ready), 32'd1);
    cycle();
    chk("bp_act", 32'(mc4), 32'h11);
    setin(0, 8'h00, 0, 0, 0, 3'd0);
    #1;
    chk("bp_full", 32'(u_if4.in_ready), 32'd0);
    setin(0, 8'h00, 1, 0, 0, 3'd0);
    cycle();
    chk("bp_shd", 32'(mc4), 32'h22);

    setin(0, 8'h00, 1, 0, 0, 3'd0);
    cycle();
    chk("emp_av", 32'(av4), 32'd1);
    chk("emp_mc", 32'(mc4), 32'h22);
    setin(1, 8'h33, 0, 0, 0, 3'd0);
    cycle();
    setin(0, 8'h00, 1, 1, 0, 3'd0);
    cycle();
    chk("ct_av", 32'(av4), 32'd1);
    chk("ct_mc", 32'(mc4), 32'h33);
    setin(0, 8'h00, 0, 1, 0, 3'd0);
    cycle();
    chk("clr_av", 32'(av4), 32'd0);
    chk("clr_mc", 32'(mc4), 32'h33);
    pp_at(3'd1); chk("clr_pp", 32'(pp4), 32'h000);

    load_take(8'h07);
    pp_at(3'b101); chk("r2_p", 32'(pp2), 32'h007);
    pp_at(3'b110); chk("r2_n", 32'(pp2), 32'h3F9);
    pp_at(3'b011); chk("r2_z", 32'(pp2), 32'h000);
    pp_at(3'b001); chk("r2_p1", 32'(pp2), 32'h007);
    setin(0, 8'h00, 0, 0, 0, 3'b010);
    cycle();
    chk("r2_hold", 32'(pp2), 32'h007);

    for (int i = 0; i < 3000; i++) begin
      setin(($urandom_range(0, 2) != 0),
            8'($urandom),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0),
            3'($urandom));
      if ($urandom_range(0, 299) == 0)
        do_reset();
      else
        cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
